ml_bit_packer: RTL and testbench

- Downstream stage of the ML demodulator top.
- Consumes the demodulator's per-bit stream (valid, LLR, hard bit) through a valid/ready handshake and drives the demodulator's read-ready input.
- Packs PACK consecutive hard bits into one word and tracks the minimum |LLR| of the word as a reliability figure.
- Presents words to the system output through a 2-entry buffer with its own valid/ready handshake.

---
 rtl/ml_bit_packer.sv | 171 +++++++++++++++++
 tb/tb_ml_bit_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_bit_packer.sv
// Packs PACK hard bits into words with a min-|LLR| reliability figure; 1-cycle push-to-visible latency.
// Backpressure: o_rd_rdy drops when the 2-entry output buffer is full, decoded from registered occupancy.

module ml_bit_packer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  input  logic             rd_rdy,
  output logic [W-1:0]     rd_dat,
  output logic [CNT_W-1:0] cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr  = wr_vld && (cnt != CNT_W'(DEPTH));
  assign do_rd  = rd_rdy && (cnt != '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      cnt <= cnt + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end
endmodule

module ml_bit_packer #(
  parameter int LLR_W = 8,
  parameter int PACK  = 8,
  parameter int LEN_W = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rd_vld,
  input  logic signed [LLR_W-1:0] i_llr,
  input  logic                    i_hard_bit,
  output logic                    o_rd_rdy,
  input  logic                    i_flush,
  output logic                    o_word_vld,
  output logic [PACK-1:0]         o_word,
  output logic [LEN_W-1:0]        o_word_len,
  output logic [LLR_W-2:0]        o_min_rel,
  input  logic                    i_word_rdy,
  output logic                    o_busy
);
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  typedef enum logic {S_EMPTY = 1'b0, S_FILL = 1'b1} state_t;

  typedef struct packed {
    logic [PACK-1:0]  word;
    logic [LEN_W-1:0] len;
    logic [LLR_W-2:0] min_rel;
  } word_t;

  state_t           state, state_d;
  logic [PACK-1:0]  acc, acc_d, acc_nxt;
  logic [LEN_W-1:0] cnt, cnt_d, cnt_nxt;
  logic [LLR_W-2:0] min_run, min_d, min_nxt;
  logic [LLR_W-1:0] neg_llr;
  logic [LLR_W-2:0] mag;
  logic             bit_acc;
  logic             flush_acc;
  logic             full_nxt;
  logic             push;
  logic             pop;
  word_t            push_dat;
  word_t            head_dat;
  logic [CNT_W-1:0] occ;

  assign o_rd_rdy  = (occ != CNT_W'(DEPTH));
  assign bit_acc   = i_rd_vld && o_rd_rdy;
  assign flush_acc = i_flush && o_rd_rdy;
  assign neg_llr   = -i_llr;

  // Most negative LLR has no positive twin; saturate it to the largest magnitude.
  always_comb begin
    mag = '1;
    if (i_llr == {1'b1, {(LLR_W-1){1'b0}}}) mag = '1;
    else if (i_llr[LLR_W-1])                mag = neg_llr[LLR_W-2:0];
    else                                    mag = i_llr[LLR_W-2:0];
  end

  always_comb begin
    acc_nxt  = acc | (bit_acc ? (PACK'(i_hard_bit) << cnt) : '0);
    cnt_nxt  = cnt + LEN_W'(bit_acc);
    min_nxt  = (bit_acc && (mag < min_run)) ? mag : min_run;
    full_nxt = (cnt_nxt == LEN_W'(PACK));
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    min_d   = min_run;
    push    = 1'b0;
    case (state)
      S_EMPTY: push = bit_acc && (flush_acc || full_nxt);
      S_FILL:  push = flush_acc || (bit_acc && full_nxt);
      default: push = 1'b0;
    endcase
    if (push) begin
      state_d = S_EMPTY;
      acc_d   = '0;
      cnt_d   = '0;
      min_d   = '1;
    end else if (bit_acc) begin
      state_d = S_FILL;
      acc_d   = acc_nxt;
      cnt_d   = cnt_nxt;
      min_d   = min_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= S_EMPTY;
      acc     <= '0;
      cnt     <= '0;
      min_run <= '1;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      min_run <= min_d;
    end
  end

  assign push_dat = '{word: acc_nxt, len: cnt_nxt, min_rel: min_nxt};
  assign pop      = o_word_vld && i_word_rdy;

  ml_bit_packer_fifo #(
    .W     ($bits(word_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_out_fifo (
    .core_clk (i_clk),
    .arst_n   (i_reset),
    .wr_vld   (push),
    .wr_dat   (push_dat),
    .rd_rdy   (pop),
    .rd_dat   (head_dat),
    .cnt      (occ)
  );

  assign o_word_vld = (occ != '0);
  assign o_word     = head_dat.word;
  assign o_word_len = head_dat.len;
  assign o_min_rel  = head_dat.min_rel;
  assign o_busy     = (cnt != '0) || (occ != '0);
endmodule

// File: tb/tb_ml_bit_packer.sv
// Directed bench for ml_bit_packer: expected words queued by stimulus, checked by a monitor on pop.
module tb_ml_bit_packer;
  localparam int LLR_W = 8;
  localparam int PACK  = 8;
  localparam int LEN_W = 4;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_rd_vld = 1'b0;
  logic signed [7:0] i_llr = '0;
  logic              i_hard_bit = 1'b0;
  logic              o_rd_rdy;
  logic              i_flush = 1'b0;
  logic              o_word_vld;
  logic [7:0]        o_word;
  logic [3:0]        o_word_len;
  logic [6:0]        o_min_rel;
  logic              i_word_rdy = 1'b0;
  logic              o_busy;

  typedef struct packed {
    logic [7:0] word;
    logic [3:0] len;
    logic [6:0] min_rel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 i_clk = ~i_clk;

  ml_bit_packer #(.LLR_W(LLR_W), .PACK(PACK), .LEN_W(LEN_W)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rd_vld   (i_rd_vld),
    .i_llr      (i_llr),
    .i_hard_bit (i_hard_bit),
    .o_rd_rdy   (o_rd_rdy),
    .i_flush    (i_flush),
    .o_word_vld (o_word_vld),
    .o_word     (o_word),
    .o_word_len (o_word_len),
    .o_min_rel  (o_min_rel),
    .i_word_rdy (i_word_rdy),
    .o_busy     (o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every pop is compared against the next expected word.
  always @(negedge i_clk) begin
    if (i_reset && o_word_vld && i_word_rdy) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h expected none", o_word);
      end else begin
        mon_e = sb.pop_front();
        check("word", 32'(o_word), 32'(mon_e.word));
        check("len", 32'(o_word_len), 32'(mon_e.len));
        check("min_rel", 32'(o_min_rel), 32'(mon_e.min_rel));
      end
    end
  end

  task automatic wait_rdy();
    int t = 0;
    @(negedge i_clk);
    while (!o_rd_rdy && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_rd_rdy) begin
      n_vec++;
      n_err++;
      $display("FAIL rd_rdy_timeout: got 0 expected 1");
    end
  endtask

  task automatic send_bit(input logic hb, input logic signed [7:0] llr, input logic fl);
    i_rd_vld   = 1'b1;
    i_hard_bit = hb;
    i_llr      = llr;
    i_flush    = fl;
    wait_rdy();
    @(posedge i_clk);
    #1;
    i_rd_vld = 1'b0;
    i_flush  = 1'b0;
  endtask

  task automatic send_flush();
    i_flush = 1'b1;
    wait_rdy();
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
  endtask

  function automatic logic signed [7:0] llr_of(input int i, input int pos, input logic signed [7:0] v);
    if (i == pos) return v;
    return (i % 2 == 1) ? -8'sd100 : 8'sd100;
  endfunction

  task automatic send_word(input logic [7:0] w, input int pos, input logic signed [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(w[i], llr_of(i, pos, v), 1'b0);
  endtask

  task automatic drain();
    int t = 0;
    while ((o_word_vld || sb.size() != 0) && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    check("drain_remaining", 32'(sb.size()), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  logic [7:0]        t1_bits;
  logic signed [7:0] t1_llr [8];
  logic [7:0]        w2;

  initial begin
    t1_bits = 8'b0100_1101;
    t1_llr  = '{8'sd20, -8'sd5, 8'sd40, 8'sd33, -8'sd90, -8'sd7, 8'sd64, -8'sd100};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_rd_rdy", 32'(o_rd_rdy), 32'd1);
    check("rst_word_vld", 32'(o_word_vld), 32'd0);
    check("rst_word", 32'(o_word), 32'd0);
    check("rst_len", 32'(o_word_len), 32'd0);
    check("rst_min", 32'(o_min_rel), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;

    // Full word with latency check
    i_word_rdy = 1'b1;
    sb.push_back('{word: 8'h4D, len: 4'd8, min_rel: 7'd5});
    for (int i = 0; i < 8; i++) begin
      send_bit(t1_bits[i], t1_llr[i], 1'b0);
      if (i == 6) check("vld_before_last", 32'(o_word_vld), 32'd0);
    end
    check("vld_after_last", 32'(o_word_vld), 32'd1);
    drain();

    // -128 saturates; flush closes a 1-bit word
    sb.push_back('{word: 8'h01, len: 4'd1, min_rel: 7'd127});
    send_bit(1'b1, -8'sd128, 1'b0);
    check("busy_partial", 32'(o_busy), 32'd1);
    send_flush();
    drain();

    // Flush together with 4th bit, then flush on empty
    sb.push_back('{word: 8'h0F, len: 4'd4, min_rel: 7'd8});
    send_bit(1'b1, 8'sd10, 1'b0);
    send_bit(1'b1, 8'sd9, 1'b0);
    send_bit(1'b1, 8'sd8, 1'b0);
    send_bit(1'b1, 8'sd12, 1'b1);
    drain();
    send_flush();
    repeat (3) @(negedge i_clk);
    check("empty_flush_vld", 32'(o_word_vld), 32'd0);
    check("empty_flush_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk);
    #1;

    // Backpressure with 24 bits
    i_word_rdy = 1'b0;
    sb.push_back('{word: 8'hA5, len: 4'd8, min_rel: 7'd17});
    sb.push_back('{word: 8'h3C, len: 4'd8, min_rel: 7'd0});
    sb.push_back('{word: 8'hF0, len: 4'd8, min_rel: 7'd100});
    fork
      begin
        send_word(8'hA5, 3, -8'sd17);
        send_word(8'h3C, 0, 8'sd0);
        send_word(8'hF0, 7, 8'sd127);
      end
      begin
        repeat (40) @(negedge i_clk);
        check("bp_rd_rdy", 32'(o_rd_rdy), 32'd0);
        check("bp_vld", 32'(o_word_vld), 32'd1);
        check("bp_hold_word", 32'(o_word), 32'hA5);
        check("bp_hold_min", 32'(o_min_rel), 32'd17);
        check("bp_busy", 32'(o_busy), 32'd1);
        @(posedge i_clk);
        #1;
        i_word_rdy = 1'b1;
      end
    join
    drain();

    // Reset mid-word with one buffered word
    i_word_rdy = 1'b0;
    send_word(8'h55, 0, 8'sd100);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 8'sd50, 1'b0);
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    check("pre_rst_vld", 32'(o_word_vld), 32'd1);
    i_reset = 1'b0;
    #1;
    check("mid_rst_vld", 32'(o_word_vld), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_rd_rdy", 32'(o_rd_rdy), 32'd1);
    @(posedge i_clk);
    #1;
    i_reset    = 1'b1;
    i_word_rdy = 1'b1;
    sb.push_back('{word: 8'hC3, len: 4'd8, min_rel: 7'd1});
    send_word(8'hC3, 2, -8'sd1);
    drain();

    // Push and pop on the same cycle at occupancy 1
    i_word_rdy = 1'b0;
    w2 = 8'h69;
    sb.push_back('{word: 8'h96, len: 4'd8, min_rel: 7'd33});
    sb.push_back('{word: 8'h69, len: 4'd8, min_rel: 7'd2});
    send_word(8'h96, 4, 8'sd33);
    for (int i = 0; i < 7; i++) send_bit(w2[i], llr_of(i, 6, -8'sd2), 1'b0);
    i_word_rdy = 1'b1;
    send_bit(w2[7], llr_of(7, 6, -8'sd2), 1'b0);
    check("pp_vld", 32'(o_word_vld), 32'd1);
    check("pp_rd_rdy", 32'(o_rd_rdy), 32'd1);
    check("pp_head", 32'(o_word), 32'h69);
    drain();
    check("final_busy", 32'(o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
